// File: rtl/csc_frame_ctrl.sv
// Frame sequencer for the RGB->YUV datapath: vs/de tracking, shadowed coefficient mode, delayed sof/eol/eof strobes, sticky timing errors.
// Optional CSC_CTRL_STATS_EN adds measured line length, lines per frame and a frame counter.
module csc_frame_ctrl #(
  parameter int H_ACTIVE = 1920,
  parameter int V_ACTIVE = 1080,
  parameter int PIPE_LAT = 2,
  parameter int CNT_W    = 12
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             vs_i,
  input  logic             de_i,
  input  logic [1:0]       cfg_mode_i,
  input  logic             cfg_update_i,
  input  logic             err_clr_i,
  output logic [1:0]       csc_mode_o,
  output logic             busy_o,
  output logic             sof_o,
  output logic             eol_o,
  output logic             eof_o,
  output logic [CNT_W-1:0] pix_cnt_o,
  output logic [CNT_W-1:0] line_cnt_o,
  output logic [2:0]       err_o
`ifdef CSC_CTRL_STATS_EN
  ,
  output logic [CNT_W-1:0] meas_h_o,
  output logic [CNT_W-1:0] meas_v_o,
  output logic [15:0]      frame_cnt_o
`endif
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_VBLANK = 2'd1;
  localparam logic [1:0] S_LINE   = 2'd2;
  localparam logic [1:0] S_HBLANK = 2'd3;

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] H_MAX   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] V_NUM   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  logic [1:0]          state, state_nxt;
  logic                vs_q;
  logic [1:0]          pend_mode;
  logic                pend_vld;
  logic [CNT_W-1:0]    lines_seen;
  logic [PIPE_LAT-1:0] sof_sr, eol_sr, eof_sr;

  logic                vs_rise, in_frame, de_fire, first_pix;
  logic                sof_int, eol_int, eof_int;
  logic [CNT_W-1:0]    pix_idx, line_idx;
  logic [2:0]          err_set;

  always_comb begin
    vs_rise   = vs_i & ~vs_q;
    in_frame  = (state != S_IDLE);
    de_fire   = in_frame & ~vs_rise & de_i;
    first_pix = de_fire & (state != S_LINE);

    // Index of the pixel/line being presented this cycle; the registered counters lag by one
    pix_idx = '0;
    if (state == S_LINE)
      pix_idx = (pix_cnt_o >= H_MAX) ? H_MAX : pix_cnt_o + CNT_W'(1);

    line_idx = line_cnt_o;
    if (state == S_VBLANK)
      line_idx = '0;
    else if (state == S_HBLANK)
      line_idx = (line_cnt_o == CNT_SAT) ? CNT_SAT : line_cnt_o + CNT_W'(1);

    sof_int = first_pix & (state == S_VBLANK);
    eol_int = de_fire & (pix_idx == H_LAST);
    eof_int = eol_int & (line_idx == V_LAST);

    err_set[0] = (state == S_LINE) & ~de_i & (pix_cnt_o < H_LAST);
    err_set[1] = de_fire & (state == S_LINE) & (pix_cnt_o == H_LAST);
    err_set[2] = vs_rise & in_frame & (lines_seen != V_NUM);

    state_nxt = state;
    if (vs_rise) begin
      state_nxt = S_VBLANK;
    end else begin
      case (state)
        S_VBLANK: if (de_i)  state_nxt = S_LINE;
        S_LINE:   if (!de_i) state_nxt = S_HBLANK;
        S_HBLANK: if (de_i)  state_nxt = S_LINE;
        default:  state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= S_IDLE;
      vs_q       <= 1'b0;
      busy_o     <= 1'b0;
      csc_mode_o <= 2'd0;
      pend_mode  <= 2'd0;
      pend_vld   <= 1'b0;
      pix_cnt_o  <= '0;
      line_cnt_o <= '0;
      lines_seen <= '0;
      err_o      <= 3'd0;
      sof_sr     <= '0;
      eol_sr     <= '0;
      eof_sr     <= '0;
    end else begin
      state  <= state_nxt;
      vs_q   <= vs_i;
      busy_o <= (state_nxt != S_IDLE);

      // A request arriving on the frame edge itself takes effect at that edge
      if (vs_rise) begin
        if (cfg_update_i)
          csc_mode_o <= cfg_mode_i;
        else if (pend_vld)
          csc_mode_o <= pend_mode;
        pend_vld <= 1'b0;
      end else if (cfg_update_i) begin
        pend_mode <= cfg_mode_i;
        pend_vld  <= 1'b1;
      end

      if (vs_rise) begin
        pix_cnt_o  <= '0;
        line_cnt_o <= '0;
        lines_seen <= '0;
      end else if (de_fire) begin
        pix_cnt_o  <= pix_idx;
        line_cnt_o <= line_idx;
        if (first_pix && lines_seen != CNT_SAT)
          lines_seen <= lines_seen + CNT_W'(1);
      end

      err_o <= (err_clr_i ? 3'd0 : err_o) | err_set;

      sof_sr <= PIPE_LAT'({sof_sr, sof_int});
      eol_sr <= PIPE_LAT'({eol_sr, eol_int});
      eof_sr <= PIPE_LAT'({eof_sr, eof_int});
    end
  end

  assign sof_o = sof_sr[PIPE_LAT-1];
  assign eol_o = eol_sr[PIPE_LAT-1];
  assign eof_o = eof_sr[PIPE_LAT-1];

`ifdef CSC_CTRL_STATS_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meas_h_o    <= '0;
      meas_v_o    <= '0;
      frame_cnt_o <= 16'd0;
    end else begin
      if (state == S_LINE && !de_i)
        meas_h_o <= pix_cnt_o + CNT_W'(1);
      if (vs_rise) begin
        frame_cnt_o <= frame_cnt_o + 16'd1;
        if (in_frame)
          meas_v_o <= lines_seen;
      end
    end
  end
`endif

endmodule

// File: tb/tb_csc_frame_ctrl.sv
// Bench for csc_frame_ctrl at H_ACTIVE=8, V_ACTIVE=4, PIPE_LAT=2; strobes are scoreboarded against a frame model.
module tb_csc_frame_ctrl;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int PL = 2;
  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          rst_n_i = 1'b0;
  logic          vs_i = 1'b0, de_i = 1'b0, cfg_update_i = 1'b0, err_clr_i = 1'b0;
  logic [1:0]    cfg_mode_i = 2'd0;
  logic [1:0]    csc_mode_o;
  logic          busy_o, sof_o, eol_o, eof_o;
  logic [CW-1:0] pix_cnt_o, line_cnt_o;
  logic [2:0]    err_o;
`ifdef CSC_CTRL_STATS_EN
  logic [CW-1:0] meas_h_o, meas_v_o;
  logic [15:0]   frame_cnt_o;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int       cyc;
    logic [2:0] s;
  } exp_t;
  exp_t sb[$];

  csc_frame_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .PIPE_LAT(PL), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .vs_i(vs_i), .de_i(de_i),
    .cfg_mode_i(cfg_mode_i), .cfg_update_i(cfg_update_i), .err_clr_i(err_clr_i),
    .csc_mode_o(csc_mode_o), .busy_o(busy_o), .sof_o(sof_o), .eol_o(eol_o), .eof_o(eof_o),
    .pix_cnt_o(pix_cnt_o), .line_cnt_o(line_cnt_o), .err_o(err_o)
`ifdef CSC_CTRL_STATS_EN
    , .meas_h_o(meas_h_o), .meas_v_o(meas_v_o), .frame_cnt_o(frame_cnt_o)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // One clock of stimulus; also retires scoreboard entries for strobes seen on the previous edge
  task automatic step(input logic vs, input logic de, input logic upd, input logic clr, input logic [2:0] e);
    exp_t x;
    @(negedge clk);
    if (sof_o | eol_o | eof_o) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL strobe_unexpected cyc=%0d got=%b want=none", cyc, {sof_o, eol_o, eof_o});
      end else begin
        x = sb.pop_front();
        if (x.cyc != cyc || x.s !== {sof_o, eol_o, eof_o}) begin
          failures++;
          $display("FAIL strobe cyc=%0d got=%b want=%b@%0d", cyc, {sof_o, eol_o, eof_o}, x.s, x.cyc);
        end
      end
    end else if (sb.size() != 0 && sb[0].cyc < cyc) begin
      checks++;
      failures++;
      x = sb.pop_front();
      $display("FAIL strobe_missing cyc=%0d got=none want=%b@%0d", cyc, x.s, x.cyc);
    end
    vs_i = vs; de_i = de; cfg_update_i = upd; err_clr_i = clr;
    if (e != 3'b000) begin
      x.cyc = cyc + PL;
      x.s   = e;
      sb.push_back(x);
    end
  endtask

  task automatic drive_line(input int len, input int ln);
    logic [2:0] e;
    for (int p = 0; p < len; p++) begin
      e = {(ln == 0 && p == 0), (p == H - 1), (p == H - 1 && ln == V - 1)};
      step(1'b0, 1'b1, 1'b0, 1'b0, e);
    end
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
  endtask

  task automatic clean_lines(input int n);
    for (int ln = 0; ln < n; ln++) drive_line(H, ln);
  endtask

  task automatic frame_start();
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
  endtask

  task automatic flush();
    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL strobe_pending got=%0d want=0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({csc_mode_o, busy_o, sof_o, eol_o, eof_o, err_o} !== 10'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=0", {csc_mode_o, busy_o, sof_o, eol_o, eof_o, err_o});
    end
    checks++;
    if (pix_cnt_o !== '0 || line_cnt_o !== '0) begin
      failures++;
      $display("FAIL reset_counters got=%0d/%0d want=0/0", pix_cnt_o, line_cnt_o);
    end
    rst_n_i = 1'b1;
    repeat (5) step(1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    checks++;
    if (busy_o !== 1'b0 || pix_cnt_o !== '0) begin
      failures++;
      $display("FAIL idle_de_ignored got busy=%b pix=%0d want busy=0 pix=0", busy_o, pix_cnt_o);
    end
  endtask

  task automatic test_clean_frame();
    frame_start();
    checks++;
    if (busy_o !== 1'b1) begin
      failures++;
      $display("FAIL busy_after_vs got=%b want=1", busy_o);
    end
    clean_lines(V);
    flush();
    checks++;
    if (err_o !== 3'b000) begin
      failures++;
      $display("FAIL clean_err got=%b want=000", err_o);
    end
    checks++;
    if (pix_cnt_o !== CW'(H - 1) || line_cnt_o !== CW'(V - 1)) begin
      failures++;
      $display("FAIL clean_counters got=%0d/%0d want=%0d/%0d", pix_cnt_o, line_cnt_o, H - 1, V - 1);
    end
  endtask

  task automatic test_mode_shadow();
    frame_start();
    drive_line(H, 0);
    cfg_mode_i = 2'd2;
    step(1'b0, 1'b0, 1'b1, 1'b0, 3'b000);
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    checks++;
    if (csc_mode_o !== 2'd0) begin
      failures++;
      $display("FAIL mode_held_midframe got=%0d want=0", csc_mode_o);
    end
    for (int ln = 1; ln < V; ln++) drive_line(H, ln);
    flush();
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
    checks++;
    if (csc_mode_o !== 2'd0) begin
      failures++;
      $display("FAIL mode_before_vs got=%0d want=0", csc_mode_o);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    checks++;
    if (csc_mode_o !== 2'd2) begin
      failures++;
      $display("FAIL mode_applied got=%0d want=2", csc_mode_o);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    clean_lines(V);
    flush();
  endtask

  task automatic test_short_long();
    frame_start();
    drive_line(H, 0);
    drive_line(H - 2, 1);
    checks++;
    if (err_o !== 3'b001) begin
      failures++;
      $display("FAIL short_line got=%b want=001", err_o);
    end
    drive_line(H + 2, 2);
    checks++;
    if (err_o !== 3'b011) begin
      failures++;
      $display("FAIL long_line got=%b want=011", err_o);
    end
    drive_line(H, 3);
    flush();
    step(1'b0, 1'b0, 1'b0, 1'b1, 3'b000);
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    checks++;
    if (err_o !== 3'b000) begin
      failures++;
      $display("FAIL err_clear got=%b want=000", err_o);
    end
  endtask

  task automatic test_mismatch();
    frame_start();
    drive_line(H, 0);
    cfg_mode_i = 2'd1;
    step(1'b0, 1'b0, 1'b1, 1'b0, 3'b000);
    drive_line(H, 1);
    drive_line(H, 2);
    flush();
    step(1'b1, 1'b0, 1'b0, 1'b1, 3'b000);
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    checks++;
    if (err_o !== 3'b100) begin
      failures++;
      $display("FAIL mismatch_set_beats_clr got=%b want=100", err_o);
    end
    checks++;
    if (csc_mode_o !== 2'd1) begin
      failures++;
      $display("FAIL mismatch_mode got=%0d want=1", csc_mode_o);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    clean_lines(V);
    flush();
  endtask

  task automatic test_extra_lines();
    step(1'b0, 1'b0, 1'b0, 1'b1, 3'b000);
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    checks++;
    if (err_o !== 3'b000) begin
      failures++;
      $display("FAIL extra_pre_clear got=%b want=000", err_o);
    end
    frame_start();
    clean_lines(V + 1);
    flush();
    checks++;
    if (line_cnt_o !== CW'(V)) begin
      failures++;
      $display("FAIL extra_line_cnt got=%0d want=%0d", line_cnt_o, V);
    end
    cfg_mode_i = 2'd3;
    step(1'b1, 1'b0, 1'b1, 1'b0, 3'b000);
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    checks++;
    if (err_o !== 3'b100 || csc_mode_o !== 2'd3) begin
      failures++;
      $display("FAIL extra_vs got err=%b mode=%0d want err=100 mode=3", err_o, csc_mode_o);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    clean_lines(V);
    flush();
  endtask

  task automatic test_reset_mid_line();
    frame_start();
    drive_line(H, 0);
    drive_line(H, 1);
    for (int p = 0; p < 5; p++) step(1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
    #2 rst_n_i = 1'b0;
    #1;
    checks++;
    if ({csc_mode_o, busy_o, sof_o, eol_o, eof_o, err_o} !== 10'd0 || pix_cnt_o !== '0 || line_cnt_o !== '0) begin
      failures++;
      $display("FAIL async_reset got=%b pix=%0d line=%0d want=0", {csc_mode_o, busy_o, sof_o, eol_o, eof_o, err_o},
               pix_cnt_o, line_cnt_o);
    end
    sb.delete();
    @(negedge clk);
    rst_n_i = 1'b1;
    repeat (10) step(1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    checks++;
    if (busy_o !== 1'b0 || pix_cnt_o !== '0 || line_cnt_o !== '0 || err_o !== 3'b000) begin
      failures++;
      $display("FAIL post_reset_resync got busy=%b pix=%0d line=%0d err=%b want 0", busy_o, pix_cnt_o, line_cnt_o, err_o);
    end
    flush();
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_mode_shadow();
    test_short_long();
    test_mismatch();
    test_extra_lines();
    test_reset_mid_line();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
